// File: rtl/conv_pkg.sv
// conv_pkg: state encoding and output-dimension helper shared by the conv sequencer slice
package conv_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} conv_seq_state_t;
    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction
endpackage

// File: rtl/conv_valid_pipe.sv
// conv_valid_pipe: shift register tracking which datapath slots hold a live window
module conv_valid_pipe #(
    parameter int DEPTH = 6
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic shift_in,
    output logic last,
    output logic empty_next
);
    logic [DEPTH-1:0] pipe;
    logic [DEPTH-1:0] pipe_next;
    assign pipe_next  = DEPTH'({pipe, shift_in});
    assign last       = pipe[DEPTH-1];
    assign empty_next = ~|pipe_next;
    always_ff @(posedge i_clock or posedge i_reset)
        if (i_reset) pipe <= '0;
        else pipe <= pipe_next;
endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer: scans window positions, drives the conv datapath and emits result writes
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W        = 6,
    parameter int IMG_H        = 6,
    parameter int KSIZE        = 3,
    parameter int CONV_LATENCY = 6,
    parameter int KRD_LATENCY  = 2,
    parameter int KSET_W       = 4,
    localparam int OUT_W = out_dim(IMG_W, KSIZE),
    localparam int OUT_H = out_dim(IMG_H, KSIZE),
    localparam int NPOS  = OUT_W * OUT_H,
    localparam int MAX_D = (OUT_W > OUT_H) ? OUT_W : OUT_H,
    localparam int RC_W  = (MAX_D > 1) ? $clog2(MAX_D) : 1,
    localparam int AD_W  = (NPOS > 1) ? $clog2(NPOS) : 1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [KSET_W-1:0] i_kernel_set,
    output logic              o_busy,
    output logic              o_done,
    output logic [KSET_W-1:0] o_kernel_addr,
    output logic              o_win_req,
    output logic [RC_W-1:0]   o_win_row,
    output logic [RC_W-1:0]   o_win_col,
    input  logic              i_win_valid,
    output logic              o_conv_rst_n,
    output logic              o_conv_enable,
    input  logic              i_overflow,
    output logic              o_wr_en,
    output logic [AD_W-1:0]   o_wr_addr,
    output logic              o_overflow
);
    localparam int LD_W = $clog2(KRD_LATENCY + 1);
    conv_seq_state_t state;
    logic [LD_W-1:0] ld_cnt;
    logic issue;
    logic pipe_empty_next;
    assign issue = o_win_req & i_win_valid;
    conv_valid_pipe #(.DEPTH(CONV_LATENCY)) u_pipe (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .shift_in   (issue),
        .last       (o_wr_en),
        .empty_next (pipe_empty_next)
    );
    always_ff @(posedge i_clock or posedge i_reset)
        if (i_reset) begin
            state         <= IDLE;
            ld_cnt        <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_kernel_addr <= '0;
            o_win_req     <= 1'b0;
            o_win_row     <= '0;
            o_win_col     <= '0;
            o_conv_rst_n  <= 1'b1;
            o_conv_enable <= 1'b0;
            o_wr_addr     <= '0;
            o_overflow    <= 1'b0;
        end else begin
            o_done       <= 1'b0;
            o_conv_rst_n <= 1'b1;
            if (o_wr_en) begin
                o_wr_addr  <= o_wr_addr + 1'b1;
                o_overflow <= o_overflow | i_overflow;
            end
            case (state)
                IDLE: if (i_start) begin
                    state         <= LOAD;
                    ld_cnt        <= '0;
                    o_busy        <= 1'b1;
                    o_kernel_addr <= i_kernel_set;
                    o_win_row     <= '0;
                    o_win_col     <= '0;
                    o_wr_addr     <= '0;
                    o_overflow    <= 1'b0;
                    o_conv_rst_n  <= 1'b0;
                    o_conv_enable <= 1'b1;
                end
                LOAD: if (ld_cnt == LD_W'(KRD_LATENCY - 1)) begin
                    state     <= RUN;
                    o_win_req <= 1'b1;
                end else begin
                    ld_cnt <= ld_cnt + 1'b1;
                end
                RUN: if (issue) begin
                    if (o_win_col == RC_W'(OUT_W - 1)) begin
                        o_win_col <= '0;
                        if (o_win_row == RC_W'(OUT_H - 1)) begin
                            o_win_row <= '0;
                            o_win_req <= 1'b0;
                            state     <= DRAIN;
                        end else begin
                            o_win_row <= o_win_row + 1'b1;
                        end
                    end else begin
                        o_win_col <= o_win_col + 1'b1;
                    end
                end
                DRAIN: if (pipe_empty_next) begin
                    state         <= DONE;
                    o_done        <= 1'b1;
                    o_conv_enable <= 1'b0;
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule
